// File: rtl/rng_sampler_if.sv
// Reader-side bundle for rng_sampler: word handshake plus sticky health/overflow status.
interface rng_sampler_if #(parameter int WIDTH = 64);
  logic             rd_req;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             overflow;
  logic             stuck;
  logic             clr_err;

  modport master (output rd_req, clr_err, input rd_ack, rd_data, rd_valid, overflow, stuck);
  modport slave  (input rd_req, clr_err, output rd_ack, rd_data, rd_valid, overflow, stuck);
endinterface

// File: rtl/rng_sampler.sv
// Captures the slow RNG macro bit stream into clk_jbus, packs it LSB-first into words and
// serves them over a level req / one-cycle ack handshake. Define RNG_SAMPLER_VN_EN for von Neumann debiasing.
module rng_sampler #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int STUCK_LIM   = 32
) (
  input  logic         clk_jbus,
  input  logic         rst,
  input  logic         rng_clk,
  input  logic         rng_data,
  input  logic         en,
  rng_sampler_if.slave rd
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int RUN_W = $clog2(STUCK_LIM + 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} rd_state_t;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    if (r >= RUN_W'(STUCK_LIM)) return RUN_W'(STUCK_LIM);
    return r + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] clk_meta_p0;
  logic [SYNC_STAGES-1:0] dat_meta_p0;
  logic                   clk_edge_p1;
  logic                   samp;
  logic                   samp_bit;
  logic                   accept;
  logic                   bit_vld;
  logic                   bit_val;

  // Stage 0: synchronisers, stage 1: rising-edge detect on synchronised rng_clk
  always_ff @(posedge clk_jbus or posedge rst) begin
    if (rst) begin
      clk_meta_p0 <= '0;
      dat_meta_p0 <= '0;
      clk_edge_p1 <= 1'b0;
    end else begin
      clk_meta_p0 <= {clk_meta_p0[SYNC_STAGES-2:0], rng_clk};
      dat_meta_p0 <= {dat_meta_p0[SYNC_STAGES-2:0], rng_data};
      clk_edge_p1 <= clk_meta_p0[SYNC_STAGES-1];
    end
  end

  assign samp     = clk_meta_p0[SYNC_STAGES-1] & ~clk_edge_p1;
  assign samp_bit = dat_meta_p0[SYNC_STAGES-1];
  assign accept   = samp & en;

`ifdef RNG_SAMPLER_VN_EN
  logic vn_pend;
  logic vn_first;

  // Pair accepted bits; a pause in en abandons a half-formed pair
  always_ff @(posedge clk_jbus or posedge rst) begin
    if (rst) begin
      vn_pend  <= 1'b0;
      vn_first <= 1'b0;
    end else if (!en) begin
      vn_pend <= 1'b0;
    end else if (accept) begin
      vn_pend <= ~vn_pend;
      if (!vn_pend) vn_first <= samp_bit;
    end
  end

  assign bit_vld = accept & vn_pend & (vn_first ^ samp_bit);
  assign bit_val = vn_first;
`else
  assign bit_vld = accept;
  assign bit_val = samp_bit;
`endif

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] word_nxt;
  logic             word_done;

  assign word_nxt  = {bit_val, shreg[WIDTH-1:1]};
  assign word_done = bit_vld && (bit_cnt == CNT_W'(WIDTH - 1));

  // Stage 2: word accumulation
  always_ff @(posedge clk_jbus or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (bit_vld) begin
      shreg   <= word_nxt;
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic             last_bit;
  logic             stuck_set;

  // A bit arriving with clr_err starts a fresh run rather than continuing the cleared one
  always_comb begin
    run_nxt = run_cnt;
    if (accept) begin
      if (rd.clr_err || run_cnt == '0 || samp_bit != last_bit) run_nxt = RUN_W'(1);
      else                                                      run_nxt = run_sat_inc(run_cnt);
    end else if (rd.clr_err) begin
      run_nxt = '0;
    end
  end

  assign stuck_set = accept && (run_nxt == RUN_W'(STUCK_LIM));

  always_ff @(posedge clk_jbus or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      if (accept) last_bit <= samp_bit;
    end
  end

  rd_state_t state;

  // Stage 3: holding register, read FSM and sticky flags
  always_ff @(posedge clk_jbus or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd.rd_ack   <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_valid <= 1'b0;
      rd.overflow <= 1'b0;
      rd.stuck    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rd.rd_req && rd.rd_valid) begin
          state     <= ACK;
          rd.rd_ack <= 1'b1;
        end
        ACK: begin
          state     <= WAIT;
          rd.rd_ack <= 1'b0;
        end
        WAIT: if (!rd.rd_req) state <= IDLE;
        default: begin
          state     <= IDLE;
          rd.rd_ack <= 1'b0;
        end
      endcase

      // The word being acked is consumed this cycle, so a coinciding completion refills instead of overflowing
      if (word_done && (!rd.rd_valid || state == ACK)) begin
        rd.rd_data  <= word_nxt;
        rd.rd_valid <= 1'b1;
      end else if (state == ACK) begin
        rd.rd_valid <= 1'b0;
      end

      if (word_done && rd.rd_valid && state != ACK) rd.overflow <= 1'b1;
      else if (rd.clr_err)                          rd.overflow <= 1'b0;

      if (stuck_set)        rd.stuck <= 1'b1;
      else if (rd.clr_err)  rd.stuck <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rng_sampler.sv
// Scoreboard bench for rng_sampler: stimulus feeds a bit-list reference model that queues expected words,
// a monitor pops and compares on every rd_ack.
module tb_rng_sampler;
  localparam int WIDTH     = 64;
  localparam int STUCK_LIM = 32;

  logic clk_jbus = 1'b0;
  logic rst      = 1'b1;
  logic rng_clk  = 1'b0;
  logic rng_data = 1'b0;
  logic en       = 1'b0;

  rng_sampler_if #(.WIDTH(WIDTH)) rd ();

  rng_sampler #(.WIDTH(WIDTH), .SYNC_STAGES(2), .STUCK_LIM(STUCK_LIM)) dut (
    .clk_jbus(clk_jbus),
    .rst     (rst),
    .rng_clk (rng_clk),
    .rng_data(rng_data),
    .en      (en),
    .rd      (rd)
  );

  always #5 clk_jbus = ~clk_jbus;

  int vecs = 0;
  int errs = 0;
  int ack_cnt = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  bit               emit_bits[$];
  bit               hold_full;
  bit               ovf_exp;
  bit               stuck_exp;
  int               run;
  bit               last_raw;
  bit               vn_have;
  bit               vn_first;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    foreach (emit_bits[i]) w[i] = emit_bits[i];
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    emit_bits.delete();
    hold_full = 0; ovf_exp = 0; stuck_exp = 0;
    run = 0; last_raw = 0; vn_have = 0; vn_first = 0;
  endtask

  task automatic model_emit(input bit b);
    emit_bits.push_back(b);
    if (emit_bits.size() == WIDTH) begin
      if (!hold_full) begin
        hold_full = 1;
        exp_q.push_back(pack_bits());
      end else begin
        ovf_exp = 1;
      end
      emit_bits.delete();
    end
  endtask

  task automatic model_accept(input bit b);
    if (run == 0 || b != last_raw) run = 1;
    else if (run < STUCK_LIM)      run = run + 1;
    last_raw = b;
    if (run == STUCK_LIM) stuck_exp = 1;
`ifdef RNG_SAMPLER_VN_EN
    if (!vn_have) begin
      vn_have = 1; vn_first = b;
    end else begin
      vn_have = 0;
      if (vn_first != b) model_emit(vn_first);
    end
`else
    model_emit(b);
`endif
  endtask

  task automatic set_en(input bit v);
    en = v;
    if (!v) vn_have = 0;
  endtask

  task automatic send_bit(input bit b, input int half);
    @(negedge clk_jbus);
    rng_data = b;
    rng_clk  = 1'b0;
    repeat (half) @(negedge clk_jbus);
    rng_clk = 1'b1;
    if (en) model_accept(b);
    repeat (half) @(negedge clk_jbus);
  endtask

  task automatic do_reset();
    @(negedge clk_jbus);
    rst = 1'b1; en = 1'b0; rng_clk = 1'b0;
    rd.rd_req = 1'b0; rd.clr_err = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_jbus);
    rst = 1'b0;
    @(negedge clk_jbus);
  endtask

  task automatic do_read(input string name);
    bit found = 0;
    @(negedge clk_jbus);
    rd.rd_req = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_jbus);
      if (rd.rd_ack) found = 1;
    end
    check(name, WIDTH'(found), WIDTH'(1));
    rd.rd_req = 1'b0;
    repeat (2) @(negedge clk_jbus);
  endtask

  task automatic clr_pulse();
    @(negedge clk_jbus);
    rd.clr_err = 1'b1;
    @(negedge clk_jbus);
    rd.clr_err = 1'b0;
    ovf_exp = 0; stuck_exp = 0; run = 0;
  endtask

  // Monitor: every acknowledged word must be the oldest expected one
  always @(negedge clk_jbus) begin
    if (!rst && rd.rd_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL ack_data: got %h, expected no acknowledge", rd.rd_data);
      end else begin
        check("ack_data", rd.rd_data, exp_q.pop_front());
      end
      hold_full = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  bit feed_done;

  initial begin
    logic [WIDTH-1:0] w0;
    int               ack_base;
    bit               found;
    rd.rd_req = 1'b0; rd.clr_err = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_jbus);
    check("rst_ack",      WIDTH'(rd.rd_ack),   '0);
    check("rst_data",     rd.rd_data,          '0);
    check("rst_valid",    WIDTH'(rd.rd_valid), '0);
    check("rst_overflow", WIDTH'(rd.overflow), '0);
    check("rst_stuck",    WIDTH'(rd.stuck),    '0);
    rst = 1'b0;
    @(negedge clk_jbus);
    set_en(1);

`ifndef RNG_SAMPLER_VN_EN
    // Alternating 1,0 stream at a 40-cycle rng_clk period
    for (int i = 0; i < 63; i++) send_bit(bit'((i + 1) % 2), 20);
    check("valid_before_64", WIDTH'(rd.rd_valid), '0);
    send_bit(1'b0, 20);
    check("valid_after_64", WIDTH'(rd.rd_valid), WIDTH'(1));
    check("alt_word",       rd.rd_data,          64'h5555_5555_5555_5555);
    check("alt_overflow",   WIDTH'(rd.overflow), '0);
    check("alt_stuck",      WIDTH'(rd.stuck),    '0);

    // Held request: one ack, valid drops, no re-ack until request cycles
    @(negedge clk_jbus);
    rd.rd_req = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_jbus);
      if (rd.rd_ack) found = 1;
    end
    check("held_req_ack", WIDTH'(found), WIDTH'(1));
    @(negedge clk_jbus);
    check("ack_one_cycle",   WIDTH'(rd.rd_ack),   '0);
    check("valid_after_ack", WIDTH'(rd.rd_valid), '0);
    ack_base = ack_cnt;
    for (int i = 0; i < 64; i++) send_bit(bit'((i + 1) % 2), 4);
    check("refill_valid", WIDTH'(rd.rd_valid), WIDTH'(1));
    check("no_reack",     WIDTH'(ack_cnt),     WIDTH'(ack_base));
    @(negedge clk_jbus);
    rd.rd_req = 1'b0;
    @(negedge clk_jbus);
    do_read("reassert_ack");

    // Never read: second word dropped, first retained
    do_reset();
    set_en(1);
    for (int i = 0; i < 127; i++) send_bit(bit'($urandom_range(0, 1)), 4);
    check("ovf_before_128", WIDTH'(rd.overflow), '0);
    w0 = (exp_q.size() > 0) ? exp_q[0] : '0;
    send_bit(bit'($urandom_range(0, 1)), 4);
    check("ovf_after_128", WIDTH'(rd.overflow), WIDTH'(1));
    check("ovf_model",     WIDTH'(ovf_exp),     WIDTH'(1));
    check("ovf_data_kept", rd.rd_data,          w0);
    check("ovf_stuck",     WIDTH'(rd.stuck),    WIDTH'(stuck_exp));
    clr_pulse();
    check("ovf_cleared", WIDTH'(rd.overflow), '0);
    do_read("ovf_drain_ack");
`endif

    // Stuck source: sets on the 32nd identical bit, survives a toggle
    do_reset();
    set_en(1);
    for (int i = 0; i < STUCK_LIM - 1; i++) send_bit(1'b0, 4);
    check("stuck_at_31", WIDTH'(rd.stuck), '0);
    send_bit(1'b0, 4);
    check("stuck_at_32", WIDTH'(rd.stuck), WIDTH'(1));
    send_bit(1'b1, 4);
    check("stuck_after_toggle", WIDTH'(rd.stuck), WIDTH'(1));
    clr_pulse();
    check("stuck_cleared", WIDTH'(rd.stuck), '0);

`ifndef RNG_SAMPLER_VN_EN
    // Asynchronous reset mid-word
    do_reset();
    set_en(1);
    for (int i = 0; i < 84; i++) send_bit(bit'($urandom_range(0, 1)), 4);
    check("pre_rst_valid", WIDTH'(rd.rd_valid), WIDTH'(1));
    @(negedge clk_jbus);
    rng_clk = 1'b0;
    repeat (4) @(negedge clk_jbus);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_ack",      WIDTH'(rd.rd_ack),   '0);
    check("arst_data",     rd.rd_data,          '0);
    check("arst_valid",    WIDTH'(rd.rd_valid), '0);
    check("arst_overflow", WIDTH'(rd.overflow), '0);
    check("arst_stuck",    WIDTH'(rd.stuck),    '0);
    @(negedge clk_jbus);
    rst = 1'b0;
    for (int i = 0; i < 63; i++) send_bit(bit'($urandom_range(0, 1)), 4);
    check("post_rst_63", WIDTH'(rd.rd_valid), '0);
    send_bit(bit'($urandom_range(0, 1)), 4);
    check("post_rst_64", WIDTH'(rd.rd_valid), WIDTH'(1));
    do_read("post_rst_ack");
`else
    // Debiasing: 0,1,1,0,0,0,1,1 emits 0,1 per group
    do_reset();
    set_en(1);
    for (int i = 0; i < 256; i++) begin
      bit b;
      case (i % 8)
        1, 2, 6, 7: b = 1'b1;
        default:    b = 1'b0;
      endcase
      send_bit(b, 4);
      if (i == 250) check("vn_before_word", WIDTH'(rd.rd_valid), '0);
    end
    check("vn_valid", WIDTH'(rd.rd_valid), WIDTH'(1));
    check("vn_word",  rd.rd_data,          64'hAAAA_AAAA_AAAA_AAAA);
    check("vn_stuck", WIDTH'(rd.stuck),    '0);
    do_read("vn_ack");
`endif

    // Random stream with en gaps and an independent reader
    do_reset();
    set_en(1);
    feed_done = 0;
    fork
      begin
        for (int i = 0; i < 260; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            set_en(0);
            repeat ($urandom_range(1, 3)) send_bit(bit'($urandom_range(0, 1)), 4);
            set_en(1);
          end
          send_bit(bit'($urandom_range(0, 1)), 4);
        end
        feed_done = 1;
      end
      begin
        while (!feed_done) begin
          @(negedge clk_jbus);
          if (rd.rd_valid) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_jbus);
            do_read("rand_ack");
          end
        end
      end
    join
    repeat (8) @(negedge clk_jbus);
    if (rd.rd_valid) do_read("rand_tail_ack");
    check("rand_queue_empty", WIDTH'(exp_q.size()), '0);
    check("rand_overflow",    WIDTH'(rd.overflow),  WIDTH'(ovf_exp));
    check("rand_stuck",       WIDTH'(rd.stuck),     WIDTH'(stuck_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
